mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares a single Avalon-style word memory between the CPU instruction-fetch port and the CPU data port. It serialises accesses, alternates fairly under contention and registers all outbound commands. It converts the slave's variable-latency `waitrequest` handshake into a one-cycle acknowledge per master. It sits between the MIPS core and the unified RAM, so a single-port RAM (boot region at 0xBFC00000) can serve both instruction and data traffic.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-master / one-slave memory arbiter.
// Carries the instruction-fetch port, the data port and the downstream
// Avalon-style slave port. The arbiter uses the slave modport. The master
// modport is the surrounding system's view: the CPU ports and the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Instruction-fetch port
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              i_waitrequest;
    logic [31:0]       i_readdata;

    // Data port
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [31:0]       d_writedata;
    logic [3:0]        d_byteenable;
    logic              d_waitrequest;
    logic [31:0]       d_readdata;

    // Shared slave port
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;

    modport slave (
        input  i_read, i_address,
        output i_waitrequest, i_readdata,
        input  d_read, d_write, d_address, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata,
        output m_read, m_write, m_address, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata
    );

    modport master (
        output i_read, i_address,
        input  i_waitrequest, i_readdata,
        output d_read, d_write, d_address, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata,
        input  m_read, m_write, m_address, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter. Instruction fetch and data traffic share one
// single-port RAM. Accesses are serialised and all slave commands come from
// registers. Under contention the two masters alternate. The slave's
// variable-latency waitrequest becomes a one-cycle acknowledge per master.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        ACK_I,
        ACK_D
    } state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [31:0]       m_writedata_q, m_writedata_d;
    logic [3:0]        m_byteenable_q, m_byteenable_d;
    logic [31:0]       i_readdata_q, i_readdata_d;
    logic [31:0]       d_readdata_q, d_readdata_d;
    logic              err_q, err_d;

    logic              i_pending;
    logic              d_pending;
    logic              grant_i;
    logic              grant_d;
    logic              d_conflict;

    // The fetch port wins when it is alone, or when the data port was served last.
    assign i_pending  = bus.i_read;
    assign d_pending  = bus.d_read | bus.d_write;
    assign grant_i    = i_pending & (~d_pending | (last_grant_q == GRANT_D));
    assign grant_d    = d_pending & ~grant_i;
    assign d_conflict = bus.d_read & bus.d_write;

    // Next-state logic: grant in IDLE, wait out the slave in REQ_x, then acknowledge.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        m_read_d       = m_read_q;
        m_write_d      = m_write_q;
        m_address_d    = m_address_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;
        i_readdata_d   = i_readdata_q;
        d_readdata_d   = d_readdata_q;
        err_d          = err_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d        = REQ_I;
                    m_read_d       = 1'b1;
                    m_write_d      = 1'b0;
                    m_address_d    = bus.i_address;
                    m_writedata_d  = '0;
                    m_byteenable_d = 4'b1111;
                end else if (grant_d) begin
                    // A simultaneous read and write is carried out as a write and flagged.
                    state_d        = REQ_D;
                    m_read_d       = bus.d_read & ~bus.d_write;
                    m_write_d      = bus.d_write;
                    m_address_d    = bus.d_address;
                    m_writedata_d  = bus.d_writedata;
                    m_byteenable_d = bus.d_byteenable;
                    if (d_conflict) begin
                        err_d = 1'b1;
                    end
                end
            end

            REQ_I: begin
                if (!bus.m_waitrequest) begin
                    i_readdata_d = bus.m_readdata;
                    m_read_d     = 1'b0;
                    m_write_d    = 1'b0;
                    last_grant_d = GRANT_I;
                    state_d      = ACK_I;
                end
            end

            REQ_D: begin
                if (!bus.m_waitrequest) begin
                    if (m_read_q) begin
                        d_readdata_d = bus.m_readdata;
                    end
                    m_read_d     = 1'b0;
                    m_write_d    = 1'b0;
                    last_grant_d = GRANT_D;
                    state_d      = ACK_D;
                end
            end

            ACK_I: begin
                state_d = IDLE;
            end

            ACK_D: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers. Reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_D;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
            i_readdata_q   <= '0;
            d_readdata_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
            i_readdata_q   <= i_readdata_d;
            d_readdata_q   <= d_readdata_d;
            err_q          <= err_d;
        end
    end

    // Each master's waitrequest is low only in its own acknowledge cycle.
    assign bus.i_waitrequest = (state_q != ACK_I);
    assign bus.d_waitrequest = (state_q != ACK_D);
    assign bus.i_readdata    = i_readdata_q;
    assign bus.d_readdata    = d_readdata_q;

    assign bus.m_read        = m_read_q;
    assign bus.m_write       = m_write_q;
    assign bus.m_address     = m_address_q;
    assign bus.m_writedata   = m_writedata_q;
    assign bus.m_byteenable  = m_byteenable_q;

    assign err               = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A small slave model stalls for a
// programmable number of cycles. Expected acknowledges (port and returned
// word) are queued when a request is driven and checked when the ack appears.
module tb_mem_arbiter;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } expAck_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        err;
    int          compared = 0;
    int          mismatched = 0;
    int          stallCycles = 0;
    int          busy = 0;
    int          cyc;
    logic        sawAck;
    logic [31:0] modelD = '0;
    expAck_t     expQ[$];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Slave model: the boot vector returns 8. Every other address returns a scrambled copy of itself.
    function automatic logic [31:0] slaveRead(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h0000_0008;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Slave stall model: waitrequest stays high for stallCycles cycles of each command.
    always @(posedge clk) begin
        if (bus.m_read || bus.m_write) busy <= busy + 1;
        else busy <= 0;
    end

    assign bus.m_waitrequest = (bus.m_read || bus.m_write) && (busy < stallCycles);
    assign bus.m_readdata    = bus.m_read ? slaveRead(bus.m_address) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic port, input logic [31:0] data);
        expAck_t e;
        e.port = port;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Called while an ack is visible: checks it against the oldest expectation.
    task automatic popAndCheck();
        expAck_t e;
        compared++;
        assert (expQ.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL sbEmpty: observed an ack, expected no ack");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkBit("ackExclusive", bus.i_waitrequest ^ bus.d_waitrequest, 1'b1);
            checkBit("ackPort", bus.i_waitrequest, e.port);
            checkVal("ackData", e.port ? bus.d_readdata : bus.i_readdata, e.data);
        end
    endtask

    // Advances at least one cycle, then up to budget cycles, until an ack appears.
    task automatic waitAck(input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (bus.i_waitrequest && bus.d_waitrequest && cycles < budget);
        compared++;
        assert (!(bus.i_waitrequest && bus.d_waitrequest)) else begin
            mismatched++;
            $error("[TB] FAIL ackTimeout: observed no ack after %0d cycles, expected an ack", cycles);
        end
        if (!(bus.i_waitrequest && bus.d_waitrequest)) popAndCheck();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_address     = '0;
        bus.d_writedata   = '0;
        bus.d_byteenable  = '0;

        // Reset held with a fetch pending: nothing may leave the arbiter.
        bus.i_read    = 1'b1;
        bus.i_address = 32'hBFC0_0000;
        repeat (3) step();
        checkBit("rstMRead", bus.m_read, 1'b0);
        checkBit("rstMWrite", bus.m_write, 1'b0);
        checkBit("rstIWait", bus.i_waitrequest, 1'b1);
        checkBit("rstDWait", bus.d_waitrequest, 1'b1);
        checkBit("rstErr", err, 1'b0);
        checkVal("rstMAddr", bus.m_address, 32'h0);
        checkVal("rstMBe", {28'b0, bus.m_byteenable}, 32'h0);
        checkVal("rstIData", bus.i_readdata, 32'h0);
        checkVal("rstDData", bus.d_readdata, 32'h0);

        // Release reset: boot fetch, zero-wait slave.
        stallCycles = 0;
        reset = 1'b1;
        pushExp(PORT_I, 32'h0000_0008);
        step();
        checkBit("bootMRead", bus.m_read, 1'b1);
        checkVal("bootMAddr", bus.m_address, 32'hBFC0_0000);
        checkVal("bootMBe", {28'b0, bus.m_byteenable}, 32'hF);
        checkVal("bootMWdata", bus.m_writedata, 32'h0);
        checkBit("bootNoAckC1", bus.i_waitrequest, 1'b1);
        step();
        checkBit("bootAckC2", bus.i_waitrequest, 1'b0);
        popAndCheck();
        bus.i_read = 1'b0;
        step();
        checkBit("bootAckOneCycle", bus.i_waitrequest, 1'b1);

        // Store with a three-cycle slave stall.
        stallCycles      = 3;
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h0000_0200;
        bus.d_writedata  = 32'h1234_5678;
        bus.d_byteenable = 4'b0011;
        pushExp(PORT_D, modelD);
        for (int c = 1; c <= 4; c++) begin
            step();
            checkBit("stHoldWrite", bus.m_write, 1'b1);
            checkBit("stHoldRead", bus.m_read, 1'b0);
            checkVal("stHoldAddr", bus.m_address, 32'h0000_0200);
            checkVal("stHoldWdata", bus.m_writedata, 32'h1234_5678);
            checkVal("stHoldBe", {28'b0, bus.m_byteenable}, 32'h3);
            checkBit("stNoAck", bus.d_waitrequest, 1'b1);
        end
        step();
        checkBit("stAckC5", bus.d_waitrequest, 1'b0);
        popAndCheck();
        bus.d_write = 1'b0;
        step();

        // Contention: both masters read continuously and must alternate I, D, I, D.
        stallCycles   = 0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0100;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0300;
        pushExp(PORT_I, slaveRead(32'h0000_0100));
        pushExp(PORT_D, slaveRead(32'h0000_0300));
        modelD = slaveRead(32'h0000_0300);
        for (int k = 0; k < 4; k++) begin
            waitAck(20, cyc);
            checkVal("contSpacing", cyc, (k == 0) ? 32'd2 : 32'd3);
            if (k == 0) begin
                bus.i_address = 32'h0000_0104;
                pushExp(PORT_I, slaveRead(32'h0000_0104));
            end else if (k == 1) begin
                bus.d_address = 32'h0000_0304;
                pushExp(PORT_D, slaveRead(32'h0000_0304));
                modelD = slaveRead(32'h0000_0304);
            end
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        step();
        checkVal("contDrained", expQ.size(), 32'd0);

        // Read and write together: performed as a write and flagged.
        stallCycles      = 1;
        bus.d_read       = 1'b1;
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h0000_0400;
        bus.d_writedata  = 32'hCAFE_F00D;
        bus.d_byteenable = 4'b1111;
        pushExp(PORT_D, modelD);
        step();
        checkBit("illWrite", bus.m_write, 1'b1);
        checkBit("illRead", bus.m_read, 1'b0);
        checkBit("illErr", err, 1'b1);
        waitAck(10, cyc);
        checkVal("illLatency", cyc, 32'd2);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        step();
        stallCycles   = 0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0700;
        pushExp(PORT_I, slaveRead(32'h0000_0700));
        waitAck(10, cyc);
        bus.i_read = 1'b0;
        checkBit("errStickyAck", err, 1'b1);
        step();
        checkBit("errStickyIdle", err, 1'b1);

        // Reset pulsed while the slave stalls a store.
        stallCycles      = 10;
        bus.d_write      = 1'b1;
        bus.d_address    = 32'h0000_0500;
        bus.d_writedata  = 32'h0BAD_0BAD;
        bus.d_byteenable = 4'b1111;
        step();
        step();
        checkBit("rmWriteBefore", bus.m_write, 1'b1);
        reset = 1'b0;
        #1;
        checkBit("rmWriteDrop", bus.m_write, 1'b0);
        checkBit("rmErrClear", err, 1'b0);
        checkBit("rmDWait", bus.d_waitrequest, 1'b1);
        checkVal("rmDData", bus.d_readdata, 32'h0);
        bus.d_write = 1'b0;
        stallCycles = 0;
        modelD = '0;
        step();
        reset = 1'b1;
        sawAck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!bus.d_waitrequest || !bus.i_waitrequest) sawAck = 1'b1;
        end
        checkBit("rmNoAck", sawAck, 1'b0);
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0800;
        pushExp(PORT_I, slaveRead(32'h0000_0800));
        waitAck(10, cyc);
        checkVal("rmRestartLatency", cyc, 32'd2);
        bus.i_read = 1'b0;
        step();

        // Fetch dropped after one cycle still completes with a single ack.
        stallCycles   = 2;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0600;
        pushExp(PORT_I, slaveRead(32'h0000_0600));
        step();
        checkBit("abMRead", bus.m_read, 1'b1);
        bus.i_read = 1'b0;
        waitAck(10, cyc);
        checkVal("abLatency", cyc, 32'd3);
        step();
        checkBit("abOnePulse", bus.i_waitrequest, 1'b1);
        checkBit("abIdle", bus.m_read, 1'b0);
        step();
        checkBit("abNoReissue", bus.m_read, 1'b0);
        checkVal("finalDrained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
